instr_sequencer: RTL and testbench

//  - Program-driven front end for simple_processor: holds a small program RAM, issues one 16-bit

---
 rtl/instr_sequencer_pkg.sv | 14 +
 rtl/seq_prog_ram.sv | 26 ++
 rtl/instr_sequencer.sv | 86 ++++++++
 tb/tb_instr_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared FSM state encoding and instruction field positions.
package instr_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, FINISH} state_t;
  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int IMM_BIT = 12;
  localparam int RX_HI = 11;
  localparam int RX_LO = 9;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;
  function automatic logic [2:0] op_of(input logic [15:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/seq_prog_ram.sv
// seq_prog_ram: program RAM with one write port and one enabled synchronous read port.
module seq_prog_ram
  import instr_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // rdata only changes on a read, so it doubles as the held instruction bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: program RAM driven issue of instructions to a processor; SEQ_TIMEOUT_EN enables the WAIT timeout abort.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] DIN,
  output logic              run,
  input  logic              proc_done,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W-1:0] pc,
  output logic              error
);
  state_t state, state_n;
  logic [ADDR_W-1:0] last_q;
  logic stop_pend, stop_now, last_hit, to_hit, idle_like;
  assign idle_like = state == IDLE || state == FINISH;
  assign busy = !idle_like;
  assign run = state == ISSUE;
  assign finished = state == FINISH;
  assign stop_now = stop_pend | stop;
  assign last_hit = pc == last_q;
  seq_prog_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk_50MHz), .rst(reset), .we(load_we && idle_like), .waddr(load_addr),
    .wdata(load_data), .re(state == FETCH), .raddr(pc), .rdata(DIN)
  );
`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  assign to_hit = state == WAIT && !proc_done && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      error <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      error <= to_hit ? 1'b1 : (idle_like && start) ? 1'b0 : error;
    end
  end
`else
  assign to_hit = 1'b0;
  assign error = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE, FINISH: state_n = start ? FETCH : state;
      FETCH:        state_n = ISSUE;
      ISSUE:        state_n = WAIT;
      WAIT:         state_n = proc_done ? (stop_now ? IDLE : last_hit ? FINISH : FETCH)
                            : to_hit ? FINISH : WAIT;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      last_q <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (idle_like && start) begin
        pc <= '0;
        last_q <= last_addr;
        stop_pend <= 1'b0;
      end else if (state == WAIT && proc_done) begin
        pc <= stop_now ? '0 : last_hit ? pc : pc + 1'b1;
        stop_pend <= 1'b0;
      end else if (busy && stop) begin
        stop_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of issue timing, stop, load gating, reset abort and timeout.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;
  logic clk_50MHz = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [4:0] last_addr = '0;
  logic load_we = 1'b0;
  logic [4:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] DIN;
  logic run;
  logic proc_done = 1'b0;
  logic busy, finished, error;
  logic [4:0] pc;
  int tests = 0;
  int fails = 0;
  logic [15:0] prog [4] = '{16'h101C, 16'h0200, 16'h32FF, 16'h52FF};

  instr_sequencer #(.DATA_W(16), .ADDR_W(5), .TIMEOUT_CYCLES(8)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .start(start), .stop(stop), .last_addr(last_addr),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .DIN(DIN), .run(run),
    .proc_done(proc_done), .busy(busy), .finished(finished), .pc(pc), .error(error)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    load_we = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_we = 1'b0;
  endtask

  task automatic kick(input logic [4:0] la);
    last_addr = la;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // waits for a run pulse, checks it, then answers with proc_done 3 cycles later
  task automatic issue(input string tag, input logic [15:0] din_exp, input logic [4:0] pc_exp,
                       input bit do_stop);
    int i = 0;
    while (!run && i < 12) begin
      step();
      i++;
    end
    chk({tag, "_run"}, run, 1);
    chk({tag, "_din"}, DIN, din_exp);
    chk({tag, "_pc"}, pc, pc_exp);
    step();
    chk({tag, "_run1cyc"}, run, 0);
    if (do_stop) stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
  endtask

  initial begin
    int n;
    step();
    step();
    chk("rst_din", DIN, 0);
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fin", finished, 0);
    chk("rst_pc", pc, 0);
    chk("rst_err", error, 0);
    reset = 1'b0;
    step();

    // 1: single instruction, exact latency
    load(5'd0, 16'h101C);
    last_addr = 5'd0;
    start = 1'b1;
    chk("t1_idle_busy", busy, 0);
    step();
    start = 1'b0;
    chk("t1_fetch_run", run, 0);
    chk("t1_fetch_busy", busy, 1);
    step();
    chk("t1_issue_run", run, 1);
    chk("t1_issue_din", DIN, 16'h101C);
    chk("t1_op", op_of(DIN), 3'b000);
    step();
    chk("t1_wait_run", run, 0);
    chk("t1_din_hold", DIN, 16'h101C);
    step();
    step();
    proc_done = 1'b1;
    chk("t1_fin_early", finished, 0);
    step();
    proc_done = 1'b0;
    chk("t1_fin", finished, 1);
    chk("t1_pc", pc, 0);
    chk("t1_busy", busy, 0);

    // 2: four-instruction program
    for (int k = 0; k < 4; k++) load(5'(k), prog[k]);
    kick(5'd3);
    for (int k = 0; k < 4; k++) issue("t2", prog[k], 5'(k), 1'b0);
    chk("t2_fin", finished, 1);
    chk("t2_pc", pc, 3);

    // 3: stop during second WAIT
    kick(5'd3);
    issue("t3a", prog[0], 5'd0, 1'b0);
    issue("t3b", prog[1], 5'd1, 1'b1);
    chk("t3_busy", busy, 0);
    chk("t3_fin", finished, 0);
    chk("t3_pc", pc, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n += int'(run);
    end
    chk("t3_no_run", n, 0);

    // 4: loads dropped while busy; proc_done ignored in ISSUE
    kick(5'd3);
    step();
    load_we = 1'b1;
    load_addr = 5'd1;
    load_data = 16'hFFFF;
    proc_done = 1'b1;
    chk("t4_issue", run, 1);
    step();
    load_we = 1'b0;
    proc_done = 1'b0;
    step();
    step();
    chk("t4_done_ignored", busy, 1);
    chk("t4_no_advance", pc, 0);
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    for (int k = 1; k < 4; k++) issue("t4", prog[k], 5'(k), 1'b0);
    kick(5'd3);
    for (int k = 0; k < 4; k++) issue("t4r", prog[k], 5'(k), 1'b0);
    chk("t4_fin", finished, 1);

    // 5: async reset in WAIT; then start+stop together (start wins)
    kick(5'd3);
    issue("t5a", prog[0], 5'd0, 1'b0);
    step();
    step();
    chk("t5_in_wait", busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_din", DIN, 0);
    chk("t5_rst_pc", pc, 0);
    chk("t5_rst_run", run, 0);
    step();
    reset = 1'b0;
    stop = 1'b1;
    kick(5'd3);
    stop = 1'b0;
    for (int k = 0; k < 4; k++) issue("t5", prog[k], 5'(k), 1'b0);
    chk("t5_fin", finished, 1);

    // full RAM; word 0 written on the same cycle as start
    for (int k = 1; k < 32; k++) load(5'(k), 16'(k * 3 + 7));
    load_we = 1'b1;
    load_addr = 5'd0;
    load_data = 16'h1ABC;
    kick(5'd31);
    load_we = 1'b0;
    issue("full0", 16'h1ABC, 5'd0, 1'b0);
    for (int k = 1; k < 32; k++) issue("full", 16'(k * 3 + 7), 5'(k), 1'b0);
    chk("full_fin", finished, 1);
    chk("full_pc", pc, 31);

    // 6: no proc_done
    load(5'd0, 16'h101C);
    kick(5'd0);
    step();
    chk("t6_issue", run, 1);
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 8; i++) step();
    chk("t6_still_wait", busy, 1);
    step();
    chk("t6_fin", finished, 1);
    chk("t6_err", error, 1);
    chk("t6_run", run, 0);
    kick(5'd0);
    chk("t6_err_clr", error, 0);
    issue("t6r", 16'h101C, 5'd0, 1'b0);
    chk("t6r_fin", finished, 1);
`else
    for (int i = 0; i < 40; i++) step();
    chk("t6_still_wait", busy, 1);
    chk("t6_err", error, 0);
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    chk("t6_fin", finished, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
